// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: 7-bit chars enter a small FIFO on a
// load/ready handshake and are serialised LSB-first on a registered tx line.
module uart_tx_fifo #(
  parameter int DIVISOR    = 104,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] in,
  output logic       ready,
  output logic       tx,
  output logic       idle,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            stopcnt_q, stopcnt_d;
  logic            tx_q, tx_d;
  logic            ready_q, idle_q, ovf_q;
  logic            push, pop, expire, nonempty;

  assign push     = load & ready_q;
  assign expire   = (baud_q == '0);
  assign nonempty = (count_q != '0);

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    baud_d    = baud_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (nonempty) begin
          pop     = 1'b1;
          shift_d = {1'b0, mem_q[rptr_q]};
          tx_d    = 1'b0;
          baud_d  = BW'(DIVISOR - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (expire) begin
          tx_d     = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          baud_d   = BW'(DIVISOR - 1);
          bitcnt_d = '0;
          state_d  = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (expire) begin
          baud_d = BW'(DIVISOR - 1);
          if (bitcnt_q == 3'd7) begin
            tx_d      = 1'b1;
            stopcnt_d = 1'b0;
            state_d   = S_STOP;
          end else begin
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (!expire) begin
          baud_d = baud_q - 1'b1;
        end else if (stopcnt_q != 1'(STOP_BITS - 1)) begin
          stopcnt_d = stopcnt_q + 1'b1;
          baud_d    = BW'(DIVISOR - 1);
        end else if (nonempty) begin
          // Chain straight into the next start bit: no idle gap.
          pop     = 1'b1;
          shift_d = {1'b0, mem_q[rptr_q]};
          tx_d    = 1'b0;
          baud_d  = BW'(DIVISOR - 1);
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      baud_q    <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      idle_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      baud_q    <= baud_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      tx_q      <= tx_d;
      ready_q   <= (count_d != CW'(FIFO_DEPTH));
      idle_q    <= (state_d == S_IDLE) && (count_d == '0);
      if (load && !ready_q)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= in;
  end

  assign ready    = ready_q;
  assign tx       = tx_q;
  assign idle     = idle_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIVISOR=4, FIFO_DEPTH=8,
// with one instance per STOP_BITS setting.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0, ovf_clr = 1'b0;
  logic [6:0] din = '0;
  logic       ready, tx, idle, overflow;
  logic       load2 = 1'b0, ovf_clr2 = 1'b0;
  logic [6:0] din2 = '0;
  logic       ready2, tx2, idle2, overflow2;

  int checks = 0;
  int failures = 0;
  logic hist [0:511];
  logic ahist [0:511];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DIVISOR(4), .FIFO_DEPTH(8), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .in(din),
    .ready(ready), .tx(tx), .idle(idle),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  uart_tx_fifo #(
    .DIVISOR(4), .FIFO_DEPTH(8), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .reset(reset), .load(load2), .in(din2),
    .ready(ready2), .tx(tx2), .idle(idle2),
    .overflow(overflow2), .ovf_clr(ovf_clr2)
  );

  // Expected line level k clocks into a frame (4 clocks per bit).
  function automatic logic fbit(input logic [6:0] ch, input int k);
    logic [7:0] b;
    b = {1'b0, ch};
    if (k < 4) return 1'b0;
    if (k < 36) return b[(k - 4) / 4];
    return 1'b1;
  endfunction

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL rst_tx got=%b exp=1", tx);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL rst_ready got=%b exp=1", ready);
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++; $display("FAIL rst_idle got=%b exp=1", idle);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL rst_ovf got=%b exp=0", overflow);
    end
    reset = 1'b0;
    lows = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      failures++; $display("FAIL rst_quiet low_cycles=%0d exp=0", lows);
    end
  endtask

  task automatic test_single();
    int bad;
    @(negedge clk);
    load = 1'b1; din = 7'd65;
    for (int t = 0; t < 46; t++) begin
      @(negedge clk);
      if (t == 0) load = 1'b0;
      hist[t] = tx; ahist[t] = idle;
    end
    bad = 0;
    for (int k = 0; k < 40; k++)
      if (hist[1 + k] !== fbit(7'd65, k)) bad++;
    for (int t = 41; t < 46; t++)
      if (hist[t] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL single_wave bad_samples=%0d exp=0", bad);
    end
    checks++;
    if (hist[0] !== 1'b1) begin
      failures++; $display("FAIL single_latency early_tx=%b exp=1", hist[0]);
    end
    checks++;
    if (ahist[1] !== 1'b0) begin
      failures++; $display("FAIL single_busy idle=%b exp=0", ahist[1]);
    end
    checks++;
    if (ahist[40] !== 1'b0) begin
      failures++; $display("FAIL single_stop idle=%b exp=0", ahist[40]);
    end
    checks++;
    if (ahist[42] !== 1'b1) begin
      failures++; $display("FAIL single_done idle=%b exp=1", ahist[42]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ch [9];
    logic pr;
    int i, refused, zeros, bad;
    ch = '{7'd72, 7'd69, 7'd76, 7'd76, 7'd79,
           7'd32, 7'd77, 7'd73, 7'd88};
    @(negedge clk);
    pr = ready; load = 1'b1; din = ch[0];
    i = 0; refused = 0; zeros = 0;
    for (int t = 0; t < 375; t++) begin
      @(negedge clk);
      if (load) begin
        if (pr) i++;
        else refused++;
      end
      hist[t] = tx;
      if (ready !== 1'b1) zeros++;
      pr = ready;
      if (i < 9) din = ch[i];
      else load = 1'b0;
    end
    for (int f = 0; f < 9; f++) begin
      bad = 0;
      for (int k = 0; k < 40; k++)
        if (hist[1 + 40 * f + k] !== fbit(ch[f], k)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL b2b_frame%0d bad_samples=%0d exp=0", f, bad);
      end
    end
    bad = 0;
    for (int t = 361; t < 375; t++)
      if (hist[t] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL b2b_tail bad_samples=%0d exp=0", bad);
    end
    checks++;
    if (refused != 0 || i != 9) begin
      failures++;
      $display("FAIL b2b_accept refused=%0d acc=%0d exp=0/9", refused, i);
    end
    checks++;
    if (zeros != 33) begin
      failures++; $display("FAIL b2b_ready_win low=%0d exp=33", zeros);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL b2b_ovf got=%b exp=0", overflow);
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++; $display("FAIL b2b_idle got=%b exp=1", idle);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] ch [9];
    logic pr;
    logic ov [0:15];
    int i, refused, bad;
    ch = '{7'd49, 7'd50, 7'd51, 7'd52, 7'd53,
           7'd54, 7'd55, 7'd56, 7'd57};
    @(negedge clk);
    pr = ready; load = 1'b1; din = ch[0];
    i = 0; refused = 0;
    for (int t = 0; t < 405; t++) begin
      @(negedge clk);
      if (load) begin
        if (pr) i++;
        else refused++;
      end
      hist[t] = tx;
      if (t < 16) ov[t] = overflow;
      pr = ready;
      if (i < 9) begin
        load = 1'b1; din = ch[i];
      end else begin
        load = (t == 8 || t == 9);
        din = 7'd90;
        ovf_clr = (t == 9 || t == 10);
      end
    end
    checks++;
    if (ov[8] !== 1'b0) begin
      failures++; $display("FAIL ovf_before got=%b exp=0", ov[8]);
    end
    checks++;
    if (ov[9] !== 1'b1) begin
      failures++; $display("FAIL ovf_set got=%b exp=1", ov[9]);
    end
    checks++;
    if (ov[10] !== 1'b1) begin
      failures++; $display("FAIL ovf_clr_vs_set got=%b exp=1", ov[10]);
    end
    checks++;
    if (ov[11] !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%b exp=0", ov[11]);
    end
    checks++;
    if (refused != 2 || i != 9) begin
      failures++;
      $display("FAIL ovf_accept refused=%0d acc=%0d exp=2/9", refused, i);
    end
    bad = 0;
    for (int f = 0; f < 9; f++)
      for (int k = 0; k < 40; k++)
        if (hist[1 + 40 * f + k] !== fbit(ch[f], k)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL ovf_stream bad_samples=%0d exp=0", bad);
    end
    bad = 0;
    for (int t = 361; t < 405; t++)
      if (hist[t] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL ovf_dropped bad_samples=%0d exp=0", bad);
    end
  endtask

  task automatic test_stop2();
    int bad, ones;
    @(negedge clk);
    load2 = 1'b1; din2 = 7'd13;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (t == 0) din2 = 7'd10;
      if (t == 1) load2 = 1'b0;
      hist[t] = tx2;
    end
    bad = 0;
    for (int k = 0; k < 44; k++)
      if (hist[1 + k] !== fbit(7'd13, k)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stop2_cr bad_samples=%0d exp=0", bad);
    end
    bad = 0;
    for (int k = 0; k < 44; k++)
      if (hist[45 + k] !== fbit(7'd10, k)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stop2_lf bad_samples=%0d exp=0", bad);
    end
    ones = 0;
    for (int t = 37; t < 60 && hist[t] === 1'b1; t++) ones++;
    checks++;
    if (ones != 8) begin
      failures++; $display("FAIL stop2_len clocks=%0d exp=8", ones);
    end
    bad = 0;
    for (int t = 89; t < 100; t++)
      if (hist[t] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || idle2 !== 1'b1) begin
      failures++;
      $display("FAIL stop2_tail bad=%0d idle=%b exp=0/1", bad, idle2);
    end
  endtask

  task automatic test_reset_mid();
    int lows, busy;
    @(negedge clk);
    load = 1'b1; din = 7'd65;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      if (t == 0) din = 7'd66;
      if (t == 1) din = 7'd67;
      if (t == 2) load = 1'b0;
    end
    checks++;
    if (tx !== 1'b0) begin
      failures++; $display("FAIL mid_bit3 got=%b exp=0", tx);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL mid_rst_tx got=%b exp=1", tx);
    end
    checks++;
    if (ready !== 1'b1 || idle !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_flags rdy=%b idle=%b ovf=%b exp=1/1/0",
               ready, idle, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    lows = 0; busy = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (idle !== 1'b1) busy++;
    end
    checks++;
    if (lows != 0 || busy != 0) begin
      failures++;
      $display("FAIL mid_residual tx_low=%0d busy=%0d exp=0/0", lows, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_stop2();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
